// File: rtl/seq_shifter_pkg.sv
// Shared types and width helpers for the iterative shifter.
// Op codes, FSM states and counter widths.
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SLA = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bits needed to hold a count 0..w inclusive.
  function automatic int rem_width(int w);
    return $clog2(w + 1);
  endfunction

  // Bits needed to hold a per-cycle step 0..s inclusive.
  function automatic int k_width(int s);
    return $clog2(s + 1);
  endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// One combinational shift step of k bits (1..STEP).
// Also flags a signed overflow for an arithmetic left step.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int STEP  = 1,
  parameter int KW    = k_width(STEP)
) (
  input  logic [WIDTH-1:0] data_i,
  input  op_e              op_i,
  input  logic [KW-1:0]    k_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] shifted_o,
  output logic             ovf_o
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] top_mask;

  // Mask of the k vacated upper bits for a right shift.
  assign top_mask = ~(ONES >> k_i);

  // Shift by k with the fill the op calls for.
  always_comb begin
    shifted_o = data_i;
    unique case (op_i)
      OP_SLL, OP_SLA: shifted_o = data_i << k_i;
      OP_SRL:         shifted_o = data_i >> k_i;
      OP_SRA: begin
        shifted_o = data_i >> k_i;
        if (sign_i) shifted_o = shifted_o | top_mask;
      end
    endcase
  end

  // Overflow when any of the top k+1 bits differs from the MSB.
  always_comb begin
    ovf_o = 1'b0;
    if (op_i == OP_SLA) begin
      for (int i = 1; i < WIDTH; i++) begin
        if (i <= int'(k_i) &&
            data_i[WIDTH-1-i] != data_i[WIDTH-1])
          ovf_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// Iterative logical/arithmetic shifter, up to STEP bits per cycle.
// Ready/valid on both sides, one operation in flight.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH   = 9,
  parameter int SHAMT_W = 4,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_ovf,
  output logic               busy
);

  localparam int REM_W = rem_width(WIDTH);
  localparam int KW    = k_width(STEP);
  localparam logic [REM_W-1:0] STEP_R = REM_W'(STEP);
  localparam logic [REM_W-1:0] WID_R  = REM_W'(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  op_e              op_q;
  logic             sign_q;
  logic             ovf_q;
  logic [REM_W-1:0] rem_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [31:0]      sh_w;
  logic [REM_W-1:0] rem_d;
  logic [REM_W-1:0] k_rem;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] step_data;
  logic             step_ovf;

  // Clamp the requested amount to WIDTH; larger shifts saturate.
  always_comb begin
    sh_w  = 32'(in_shamt);
    rem_d = (sh_w > 32'(WIDTH)) ? WID_R : REM_W'(sh_w);
  end

  // Bits shifted this cycle: min(STEP, rem).
  always_comb begin
    k_rem = (rem_q < STEP_R) ? rem_q : STEP_R;
    k     = KW'(k_rem);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .data_i    (data_q),
    .op_i      (op_q),
    .k_i       (k),
    .sign_i    (sign_q),
    .shifted_o (step_data),
    .ovf_o     (step_ovf)
  );

  // Control FSM with datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      op_q        <= OP_SLL;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= in_data;
            op_q       <= op_e'(in_op);
            sign_q     <= in_data[WIDTH-1];
            ovf_q      <= 1'b0;
            rem_q      <= rem_d;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (rem_d != '0) begin
              state_q <= SHIFT;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          data_q <= step_data;
          rem_q  <= rem_q - k_rem;
          if (op_q == OP_SLA)
            ovf_q <= ovf_q | step_ovf;
          if (rem_q == k_rem) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = data_q;
  assign out_ovf   = ovf_q;

endmodule
